// File: rtl/traffic_phase_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// traffic_phase_sequencer
//
// Round-robin right-of-way sequencer for NUM_APPR intersection approaches.
// Each served approach gets GREEN, then YELLOW, then an ALL_RED clearance.
// Approaches without demand are skipped. The active approach rests in green
// while nobody else is waiting.
//
// Optional feature: define TPS_PED_EN to add the pedestrian request latch and
// the WALK interval, along with the ped_req and walk ports.
//
// Ports
//   clk      : clock
//   rst      : asynchronous, active-high reset (all lamps red at once)
//   en       : run enable; 0 freezes the timer and all state
//   demand   : per-approach vehicle demand, level-sensitive
//   ped_req  : pedestrian request pulse              (TPS_PED_EN only)
//   light    : 3-bit lamp code per approach, [3i+2:3i] = approach i
//              (001 green, 010 yellow, 100 red)
//   walk     : walk lamp                              (TPS_PED_EN only)
//   cur_appr : approach owning, or last owning, right-of-way
//   phase    : 0 ALL_RED, 1 GREEN, 2 YELLOW, 3 WALK
// -----------------------------------------------------------------------------
module traffic_phase_sequencer #(
  parameter int NUM_APPR  = 4,
  parameter int CNT_W     = 8,
  parameter int GREEN_T   = 30,
  parameter int YELLOW_T  = 5,
  parameter int ALL_RED_T = 2,
  parameter int PED_T     = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [NUM_APPR-1:0]         demand,
`ifdef TPS_PED_EN
  input  logic                        ped_req,
`endif
  output logic [3*NUM_APPR-1:0]       light,
`ifdef TPS_PED_EN
  output logic                        walk,
`endif
  output logic [$clog2(NUM_APPR)-1:0] cur_appr,
  output logic [2:0]                  phase
);

  localparam int AW = $clog2(NUM_APPR);

  typedef enum logic [2:0] {
    ST_ALL_RED = 3'd0,
    ST_GREEN   = 3'd1,
    ST_YELLOW  = 3'd2,
    ST_WALK    = 3'd3
  } state_t;

  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;

  localparam logic [3*NUM_APPR-1:0] ALL_RED_LAMPS = {NUM_APPR{LAMP_RED}};

  // Timer reload values: an interval of length T counts T-1 down to 0.
  localparam logic [CNT_W-1:0] GREEN_LOAD   = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] YELLOW_LOAD  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALL_RED_LOAD = CNT_W'(ALL_RED_T - 1);
  localparam logic [CNT_W-1:0] PED_LOAD     = CNT_W'(PED_T - 1);
  localparam logic [CNT_W-1:0] TIMER_ONE    = CNT_W'(1);
  localparam logic [AW:0]      APPR_CNT     = (AW+1)'(NUM_APPR);

  state_t             state;
  logic [CNT_W-1:0]   timer;
  logic [AW-1:0]      nxt;
  logic [NUM_APPR-1:0] other_vec;
  logic               other_dem;
  logic               ped_pend;

  // Lamp word for a given state and owning approach.
  function automatic logic [3*NUM_APPR-1:0] lamps(input state_t st,
                                                   input logic [AW-1:0] appr);
    logic [3*NUM_APPR-1:0] l;
    l = ALL_RED_LAMPS;
    for (int i = 0; i < NUM_APPR; i++) begin
      if (appr == AW'(i)) begin
        if (st == ST_GREEN)       l[3*i +: 3] = LAMP_GREEN;
        else if (st == ST_YELLOW) l[3*i +: 3] = LAMP_YELLOW;
      end
    end
    return l;
  endfunction

  // Next approach to serve: first demanding approach after cur_appr, with
  // cur_appr itself considered last. Scanning from the far end lets the
  // nearest hit overwrite farther ones. With no demand at all, step by one.
  // NOTE: every variable written in always_comb gets a value before any
  // conditional assignment, so no path leaves it holding an old value (latch).
  always_comb begin
    logic [AW:0] sum;
    nxt = '0;
    sum = '0;
    for (int k = NUM_APPR; k >= 1; k--) begin
      sum = {1'b0, cur_appr} + (AW+1)'(k);
      if (sum >= APPR_CNT) sum = sum - APPR_CNT;
      if (demand[sum[AW-1:0]] || (k == 1 && !(|demand))) nxt = sum[AW-1:0];
    end
  end

  // Demand from anyone other than the green owner, including a waiting
  // pedestrian, ends rest-in-green.
  always_comb begin
    other_vec           = demand;
    other_vec[cur_appr] = 1'b0;
  end
  assign other_dem = (|other_vec) | ped_pend;

`ifdef TPS_PED_EN
  // Request latch. It keeps listening while en=0. On the WALK entry edge a
  // simultaneous new request wins, so it gets served on the next cycle round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                              ped_pend <= 1'b0;
    else if (ped_req)                                     ped_pend <= 1'b1;
    else if (en && state == ST_ALL_RED && timer == '0)    ped_pend <= 1'b0;
  end

  // The walk lamp is a decode of the registered state only.
  assign walk = (state == ST_WALK);
`else
  assign ped_pend = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples the pre-edge values; the asynchronous reset drives
  // the lamps to red immediately, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_ALL_RED;
      timer    <= ALL_RED_LOAD;
      cur_appr <= AW'(NUM_APPR - 1);
      light    <= ALL_RED_LAMPS;
    end else if (en) begin
      case (state)
        ST_ALL_RED: begin
          if (timer != '0) begin
            timer <= timer - TIMER_ONE;
          end else if (ped_pend) begin
            state <= ST_WALK;
            timer <= PED_LOAD;
            light <= ALL_RED_LAMPS;
          end else begin
            state    <= ST_GREEN;
            timer    <= GREEN_LOAD;
            cur_appr <= nxt;
            light    <= lamps(ST_GREEN, nxt);
          end
        end
        ST_GREEN: begin
          // At zero the timer holds, which is the rest-in-green condition.
          if (timer != '0) begin
            timer <= timer - TIMER_ONE;
          end else if (other_dem) begin
            state <= ST_YELLOW;
            timer <= YELLOW_LOAD;
            light <= lamps(ST_YELLOW, cur_appr);
          end
        end
        ST_YELLOW: begin
          if (timer != '0) begin
            timer <= timer - TIMER_ONE;
          end else begin
            state <= ST_ALL_RED;
            timer <= ALL_RED_LOAD;
            light <= ALL_RED_LAMPS;
          end
        end
        ST_WALK: begin
          if (timer != '0) begin
            timer <= timer - TIMER_ONE;
          end else begin
            state    <= ST_GREEN;
            timer    <= GREEN_LOAD;
            cur_appr <= nxt;
            light    <= lamps(ST_GREEN, nxt);
          end
        end
        default: begin
          // Corrupted encoding: fall back to a safe clearance interval.
          state <= ST_ALL_RED;
          timer <= ALL_RED_LOAD;
          light <= ALL_RED_LAMPS;
        end
      endcase
    end
  end

  assign phase = state;

endmodule

// File: doc/traffic_phase_sequencer.md
# traffic_phase_sequencer

Parametrised N-approach intersection sequencer. It rotates right-of-way round-robin across `NUM_APPR` approaches through green, yellow and all-red intervals. Approaches with no vehicle demand are skipped, and the active approach rests in green while no other approach demands. It sits between the detector-conditioning logic (demand inputs) and the lamp drivers (one 3-bit lamp code per approach), and supersedes the fixed four-road timer controller.

## Interface
- `NUM_APPR`, default 4: number of approaches, 2..8.
- `CNT_W`, default 8: interval timer width; must hold max(all `*_T`) - 1.
- `GREEN_T`, default 30: minimum green length in cycles, ≥1.
- `YELLOW_T`, default 5: yellow length in cycles, ≥1.
- `ALL_RED_T`, default 2: all-red clearance length in cycles, ≥1.
- `PED_T`, default 10: walk length in cycles, ≥1; used only with `TPS_PED_EN`.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `en`, in, 1: run enable. When 0, the timer and all state are frozen.
- `demand`, in, `NUM_APPR`: per-approach vehicle demand, level-sensitive, synchronous to `clk`.
- `ped_req`, in, 1: pedestrian request pulse. Present only with `TPS_PED_EN`.
- `light`, out, 3*`NUM_APPR`: lamp code per approach. Slice [3i+2:3i] drives approach i. Codes: 3'b001 green, 3'b010 yellow, 3'b100 red.
- `walk`, out, 1: walk lamp. Present only with `TPS_PED_EN`.
- `cur_appr`, out, clog2(`NUM_APPR`): approach currently owning or last owning right-of-way.
- `phase`, out, 3: state code. 0 ALL_RED, 1 GREEN, 2 YELLOW, 3 WALK.

## Operation
- **States:** ALL_RED, GREEN, YELLOW, WALK.
- **Timer:** on entry to a state with length T, `timer` loads T-1. It decrements each enabled cycle and the state expires when `timer`==0.
- **Lamp outputs:**
  - GREEN: `light` of `cur_appr` = 001, all other approaches = 100.
  - YELLOW: `light` of `cur_appr` = 010, all other approaches = 100.
  - ALL_RED and WALK: every approach = 100.
  - Outputs are decoded only from registered state; there is no combinational path from any input to any output.
- **GREEN:**
  - On expiry, if `other_dem` = (`demand` with the `cur_appr` bit masked) | `ped_pend` is nonzero, go to YELLOW.
  - Otherwise rest in GREEN with `timer` held at 0, and leave on the first cycle `other_dem` becomes nonzero.
- **YELLOW:** on expiry, go to ALL_RED.
- **ALL_RED:** on expiry:
  - If `ped_pend` is set (`TPS_PED_EN`), go to WALK.
  - Otherwise go to GREEN of `nxt`.
- **`nxt` selection:** the first approach with `demand`=1 scanning `cur_appr`+1, +2, … modulo `NUM_APPR`, including `cur_appr` last. If no approach has demand, `nxt` = (`cur_appr`+1) mod `NUM_APPR`.
  - `nxt` is sampled on the expiry cycle; `cur_appr` updates on the GREEN entry edge.
- **WALK:** `walk`=1. On expiry, go to GREEN of `nxt`, selected as in ALL_RED.
- **Reset values:** phase=ALL_RED, `timer`=`ALL_RED_T`-1, `cur_appr`=`NUM_APPR`-1, all `light`=100, `walk`=0, `ped_pend`=0. The first green after reset goes to approach 0 if it has demand.
- **Reset mid-interval:** rst asserted mid-interval forces all lamps to red immediately (asynchronously); no yellow is shown.
- **Illegal phase encoding:** next state is ALL_RED with `timer`=`ALL_RED_T`-1.

## Timing
- State length in enabled cycles: GREEN ≥ `GREEN_T`, YELLOW = `YELLOW_T`, ALL_RED = `ALL_RED_T`, WALK = `PED_T`.
- A demand change during ALL_RED affects `nxt` only if it is present on the expiry cycle.
- `en`=0 freezes everything, so interval lengths are counted in `en`=1 cycles only. Inputs sampled while `en`=0 have no effect, except `ped_req`, which is still latched.
- **`ped_pend` handling:**
  - Set on any cycle with `ped_req`=1.
  - Cleared on the WALK entry edge.
  - If `ped_req`=1 on that same edge, set wins: `ped_pend` stays 1 and is served at the next ALL_RED expiry.

## Configuration
- **`TPS_PED_EN` defined:**
  - `ped_req` and `walk` ports exist.
  - The `ped_pend` latch and the WALK state are implemented.
  - A pending request also counts as demand for ending rest-in-green.
- **`TPS_PED_EN` undefined:**
  - No `ped_req` or `walk` ports.
  - `ped_pend` is tied to 0 and WALK is unreachable.
  - Sequencing is GREEN→YELLOW→ALL_RED→GREEN only.

## Test plan
All scenarios use `NUM_APPR`=4, `GREEN_T`=4, `YELLOW_T`=2, `ALL_RED_T`=1, `PED_T`=3, `en`=1 unless stated.
- **Full rotation:** `demand`=4'b1111 after reset → 1 cycle all red; then approaches 0,1,2,3,0 in turn, each 4 cycles 001, 2 cycles 010, 1 cycle all 100. Period is 28 cycles.
- **Skip and rest:** `demand`=4'b0101 → sequence 0,2,0,2 with 1 and 3 never green. `demand`=4'b0001 → approach 0 rests green indefinitely. Raising `demand`[3] yields 010 on approach 0 on the next cycle.
- **No demand:** `demand`=0 → approach 0 greens and rests. Then `demand`=4'b0100 → yellow, all-red, then approach 2 green.
- **Enable and reset:** drop `en` for 5 cycles mid-yellow → yellow lasts 7 wall cycles total. Assert rst mid-green → all lamps 100 in the same cycle; after release, `cur_appr`=3 and the next green is approach 0.
- **Pedestrian (`TPS_PED_EN`):** `ped_req` pulse during approach 1 green with `demand`=4'b0010 → yellow, all-red, 3 cycles `walk`=1 with all 100, then approach 1 green. A `ped_req` on the WALK entry edge → a second walk after the next all-red.
